// File: rtl/evbox_pulse_drv.sv
// evbox_pulse_drv: per-channel level/pulse event driver with valid/ready command input
module evbox_pulse_drv #(
  parameter int N = 4,
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_mode,
  input  logic [N-1:0] cmd_mask,
  input  logic [W-1:0] cmd_width,
  output logic [N-1:0] data_out,
  output logic [N-1:0] pulsing,
  output logic [N-1:0] done
);
  typedef enum logic {IDLE, PULSE} state_t;
  state_t st [N];
  state_t st_nx [N];
  logic [W-1:0] cnt [N];
  logic [W-1:0] cnt_nx [N];
  logic [N-1:0] data_nx, done_nx;
  logic acc, is_pulse;
  // pulse commands stall while any targeted channel is still running
  always_comb begin
    for (int i = 0; i < N; i++) pulsing[i] = st[i] == PULSE;
    is_pulse = cmd_mode == 2'b10;
    cmd_ready = !is_pulse || ~|(cmd_mask & pulsing);
    acc = cmd_valid && cmd_ready;
  end
  // per-channel next state; a level command overrides the terminal count
  always_comb begin
    st_nx = st;
    cnt_nx = cnt;
    data_nx = data_out;
    done_nx = '0;
    for (int i = 0; i < N; i++) begin
      if (acc && cmd_mask[i] && !is_pulse) begin
        st_nx[i] = IDLE;
        cnt_nx[i] = '0;
        data_nx[i] = cmd_mode == 2'b00 ? 1'b0 : cmd_mode == 2'b01 ? 1'b1 : ~data_out[i];
      end else if (acc && cmd_mask[i]) begin
        st_nx[i] = PULSE;
        cnt_nx[i] = cmd_width == '0 ? '0 : cmd_width - W'(1);
        data_nx[i] = 1'b1;
      end else if (st[i] == PULSE && cnt[i] == '0) begin
        st_nx[i] = IDLE;
        data_nx[i] = 1'b0;
        done_nx[i] = 1'b1;
      end else if (st[i] == PULSE) begin
        cnt_nx[i] = cnt[i] - W'(1);
      end
    end
  end
  // state register; reset aborts pulses silently and drops any command
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      st <= '{default: IDLE};
      cnt <= '{default: '0};
      data_out <= '0;
      done <= '0;
    end else begin
      st <= st_nx;
      cnt <= cnt_nx;
      data_out <= data_nx;
      done <= done_nx;
    end
  end
endmodule

// File: doc/evbox_pulse_drv.md
Name: evbox_pulse_drv

Overview:
Event-output driver that generates the `data_out` vector consumed by the LC/GC event IO box output stage.
- Takes host commands (set, clear, toggle or timed pulse) over a valid/ready handshake and applies them to a per-channel mask.
- Holds static levels, or runs per-channel pulse-width down-counters.
- Reports per-channel pulse completion.

Parameters:
- N, 4, number of event output channels (matches output stage width).
- W, 16, pulse-width counter width in bits.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  synchronous reset, active-low.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command can be accepted this cycle.
- cmd_mode  input  2  00 clear, 01 set, 10 pulse, 11 toggle.
- cmd_mask  input  N  channels affected by the command.
- cmd_width  input  W  pulse length in clk cycles (pulse mode only).
- data_out  output  N  registered event levels to output stage.
- pulsing  output  N  channel currently running a timed pulse.
- done  output  N  one-cycle strobe per channel at pulse end.

Behaviour:
- Reset: synchronous only; takes effect at a rising edge with reset_n=0.
  - data_out=0, pulsing=0, done=0, all counters=0.
  - A pulse in progress is aborted without a done strobe.
  - Commands presented during reset are ignored.
- Accept rule: accept = cmd_valid & cmd_ready & reset_n, evaluated at the rising edge.
- cmd_ready is combinational:
  - cmd_mode != 10: cmd_ready=1.
  - cmd_mode == 10: cmd_ready = ~|(cmd_mask & pulsing).
  - A pulse is never retriggered on a running channel; the requester waits.
- Latency: the effect of an accepted command is visible on data_out at the next cycle (1-cycle latency).
- cmd_mask = 0 is accepted and has no effect.
- Per-channel state machine, independent per bit i, states IDLE and PULSE.
  - IDLE, accepted pulse with mask[i]:
    - go to PULSE; data_out[i]<=1; pulsing[i]<=1.
    - cnt[i] <= max(cmd_width,1)-1. cmd_width=0 behaves as 1.
  - PULSE, cnt[i]!=0, no level command on i: cnt[i]<=cnt[i]-1; data_out[i] held at 1.
  - PULSE, cnt[i]==0:
    - go to IDLE; data_out[i]<=0; pulsing[i]<=0; done[i]<=1 for exactly one cycle.
    - done[i] is high in the same cycle data_out[i] first reads 0.
  - Result: data_out[i] is high for exactly max(cmd_width,1) cycles.
  - Maximum pulse: 2^W-1 cycles (cmd_width all ones); no wrap-around.
- Level commands (clear, set, toggle) with mask[i]:
  - IDLE: data_out[i] <= 0, 1 or ~data_out[i] respectively.
  - PULSE: the pulse is cancelled. State->IDLE, pulsing[i]<=0, cnt[i]<=0, no done strobe. data_out[i] <= 0 for clear, 1 for set, 0 for toggle (toggle of a high pulsing bit).
  - A level command arriving in the same cycle as the terminal count (cnt==0) wins: no done strobe, and the level follows the command.
- Channels not in cmd_mask are unaffected by the command and continue their own state machine.
- A pulse command on mask bits that are all IDLE while other channels pulse is accepted. Channel timers are fully independent.
- done is otherwise 0. Multiple done bits may assert simultaneously.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with cmd_valid=1, mode 01, mask 1111 -> data_out=0000, pulsing=0000, done=0000, nothing applied; after release the command applies next cycle -> data_out=1111.
- Pulse: mode 10, mask 0001, width 5, accepted at cycle t -> data_out[0]=1 for cycles t+1..t+5, 0 at t+6 with done=0001 only at t+6; cmd_width=0 -> exactly 1-cycle pulse.
- Retrigger block: while ch0 pulses (width 100), pulse on mask 0011 -> cmd_ready=0 until ch0 done; pulse on mask 0010 -> accepted immediately, both run independently with correct widths.
- Level abort: ch2 pulsing width 10; after 4 cycles issue set on mask 0100 -> data_out[2] stays 1, pulsing[2]=0, no done; toggle on mask 0100 then -> data_out[2]=0.
- Terminal collision: clear on ch1 in exactly the cycle its cnt==0 -> data_out[1]=0, done[1] never asserts.
- Mid-pulse reset: width 0xFFFF on all channels, reset_n=0 for 1 cycle after 50 cycles -> all outputs 0 next cycle, no done; a new pulse of width 3 afterwards gives a correct 3-cycle pulse.
